inst_fetch_unit: RTL and testbench

- Front-end fetch stage: owns the PC, issues one 64-bit I-cache read per fetch group, and splits the response into up to two instructions plus PCs.
- Pushes the result into the instruction buffer through its fetch interface (`inst_1`/`inst_2`, `pc_1`/`pc_2`, `is_inst*_valid`, `fetch_inst_*_en`).
- Producer end of the instbuffer interface; honours buffer backpressure and branch/exception redirects.

---
 rtl/inst_fetch_unit.sv | 87 ++++++++
 tb/tb_inst_fetch_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC owner that fetches 64-bit groups from the I-cache and
// splits each response into up to two instructions for the instruction buffer.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] new_pc_i,
  input  logic        stall_i,
  output logic        icache_req_o,
  output logic [31:0] icache_addr_o,
  input  logic        icache_req_ready_i,
  input  logic        icache_rvalid_i,
  input  logic [63:0] icache_rdata_i,
  output logic [31:0] inst_1_o,
  output logic [31:0] inst_2_o,
  output logic [31:0] pc_1_o,
  output logic [31:0] pc_2_o,
  output logic        is_inst1_valid,
  output logic        is_inst2_valid,
  output logic        fetch_inst_1_en,
  output logic        fetch_inst_2_en
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;
  state_t      state_q;
  logic [31:0] pc_q, inst_1_q, inst_2_q, pc_1_q, pc_2_q;
  logic [63:0] hold_q, grp;
  logic        v1_q, v2_q, emit, al, go_drop;
  assign icache_req_o    = state_q == REQ;
  assign icache_addr_o   = {pc_q[31:3], 3'b000};
  assign grp             = state_q == HOLD ? hold_q : icache_rdata_i;
  assign al              = !pc_q[2];
  assign emit            = !flush && !stall_i && ((state_q == WAIT && icache_rvalid_i) || state_q == HOLD);
  // a flush with a response still in flight must swallow that stale response
  assign go_drop         = (state_q == REQ && icache_req_ready_i) ||
                           ((state_q == WAIT || state_q == DROP) && !icache_rvalid_i);
  assign inst_1_o        = inst_1_q;
  assign inst_2_o        = inst_2_q;
  assign pc_1_o          = pc_1_q;
  assign pc_2_o          = pc_2_q;
  assign is_inst1_valid  = v1_q;
  assign is_inst2_valid  = v2_q;
  assign fetch_inst_1_en = v1_q;
  assign fetch_inst_2_en = v2_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      hold_q   <= '0;
      inst_1_q <= '0;
      inst_2_q <= '0;
      pc_1_q   <= '0;
      pc_2_q   <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
    end else begin
      v1_q <= emit;
      v2_q <= emit && al;
      if (emit) begin
        inst_1_q <= al ? grp[31:0] : grp[63:32];
        inst_2_q <= al ? grp[63:32] : '0;
        pc_1_q   <= pc_q;
        pc_2_q   <= al ? pc_q + 32'd4 : '0;
        pc_q     <= pc_q + (al ? 32'd8 : 32'd4);
      end
      if (flush) begin
        pc_q    <= {new_pc_i[31:2], 2'b00};
        state_q <= go_drop ? DROP : REQ;
      end else begin
        case (state_q)
          IDLE: state_q <= REQ;
          REQ:  state_q <= icache_req_ready_i ? WAIT : REQ;
          WAIT: begin
            if (icache_rvalid_i) begin
              hold_q  <= icache_rdata_i;
              state_q <= stall_i ? HOLD : REQ;
            end
          end
          HOLD: state_q <= stall_i ? HOLD : REQ;
          DROP: state_q <= icache_rvalid_i ? REQ : DROP;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: bench acting as I-cache and instbuffer, checked against a
// transaction-level model of PC progression, group splitting and redirects.
module tb_inst_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h1c000000;
  logic        clk = 0, rst = 1, flush = 0, stall_i = 0, rdy = 0, rvalid = 0;
  logic [31:0] new_pc = 0;
  logic [63:0] rdata = 0;
  logic        icache_req_o, is_inst1_valid, is_inst2_valid, fetch_inst_1_en, fetch_inst_2_en;
  logic [31:0] icache_addr_o, inst_1_o, inst_2_o, pc_1_o, pc_2_o;

  inst_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .new_pc_i(new_pc), .stall_i(stall_i),
    .icache_req_o(icache_req_o), .icache_addr_o(icache_addr_o),
    .icache_req_ready_i(rdy), .icache_rvalid_i(rvalid), .icache_rdata_i(rdata),
    .inst_1_o(inst_1_o), .inst_2_o(inst_2_o), .pc_1_o(pc_1_o), .pc_2_o(pc_2_o),
    .is_inst1_valid(is_inst1_valid), .is_inst2_valid(is_inst2_valid),
    .fetch_inst_1_en(fetch_inst_1_en), .fetch_inst_2_en(fetch_inst_2_en)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0, groups = 0;
  logic [31:0] exp_pc = RST_PC, acc_addr = 0, exp_i1 = 0, exp_i2 = 0, exp_p1 = 0, exp_p2 = 0;
  logic [63:0] pend_d = 0, ovr = 0;
  bit outst = 0, stale = 0, pend = 0, exp_en = 0, exp_v2 = 0, use_ovr = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic emit(input logic [63:0] d);
    exp_en = 1;
    exp_p1 = exp_pc;
    if (!exp_pc[2]) begin
      exp_i1 = d[31:0]; exp_i2 = d[63:32]; exp_p2 = exp_pc + 4; exp_v2 = 1; exp_pc += 8;
    end else begin
      exp_i1 = d[63:32]; exp_i2 = 0; exp_p2 = 0; exp_v2 = 0; exp_pc += 4;
    end
  endtask

  // One clock: check last edge's outputs, drive inputs, predict the next edge.
  task automatic cyc(input bit r, input bit st, input bit fl, input bit rv, input logic [31:0] npc);
    bit acc, del;
    @(negedge clk);
    chk("en1", fetch_inst_1_en, exp_en);
    chk("v1", is_inst1_valid, exp_en);
    chk("en2", fetch_inst_2_en, exp_en & exp_v2);
    chk("v2", is_inst2_valid, exp_en & exp_v2);
    if (exp_en) begin
      chk("inst1", inst_1_o, exp_i1);
      chk("pc1", pc_1_o, exp_p1);
      chk("inst2", inst_2_o, exp_i2);
      chk("pc2", pc_2_o, exp_p2);
      groups++;
    end
    if (icache_req_o) chk("single_outstanding", outst | pend, 0);
    rdy = r; stall_i = st; flush = fl; new_pc = npc; rvalid = rv && outst;
    rdata = !rvalid || stale ? {$urandom, $urandom} :
            use_ovr ? ovr : {word(acc_addr + 4), word(acc_addr)};
    acc = icache_req_o && r;
    del = rvalid;
    if (acc) chk("req_addr", icache_addr_o, {exp_pc[31:3], 3'b000});
    exp_en = 0;
    if (fl) begin
      if (del) begin outst = 0; stale = 0; end
      else if (acc) begin outst = 1; stale = 1; end
      else if (outst) stale = 1;
      pend = 0;
      exp_pc = {npc[31:2], 2'b00};
    end else begin
      if (pend && !st) begin emit(pend_d); pend = 0; end
      if (del) begin
        outst = 0;
        if (stale) stale = 0;
        else if (!st) emit(rdata);
        else begin pend = 1; pend_d = rdata; end
      end
      if (acc) begin outst = 1; acc_addr = icache_addr_o; end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", icache_req_o, 0);
    chk("rst_en1", fetch_inst_1_en, 0);
    chk("rst_en2", fetch_inst_2_en, 0);
    chk("rst_inst1", inst_1_o, 0);
    chk("rst_pc1", pc_1_o, 0);
    chk("rst_addr", icache_addr_o, RST_PC);
    rst = 0;
    // basic aligned fetch from reset PC
    repeat (8) cyc(1, 0, 0, 1, 0);
    // redirect to an unaligned target while requesting (not accepted)
    for (int i = 0; i < 10 && !(icache_req_o && !outst); i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 32'h1c000107);
    repeat (8) cyc(1, 0, 0, 1, 0);
    // stall across response arrival with known data
    use_ovr = 1; ovr = 64'hAABBCCDD_11223344;
    for (int i = 0; i < 20 && !pend; i++) cyc(1, 1, 0, 1, 0);
    chk("stall_reached", pend, 1);
    repeat (3) cyc(1, 1, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    use_ovr = 0;
    repeat (4) cyc(1, 0, 0, 1, 0);
    // flush while waiting; stale response two cycles later
    for (int i = 0; i < 10 && !outst; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 32'h20000010);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    repeat (6) cyc(1, 0, 0, 1, 0);
    // flush coincident with the response
    for (int i = 0; i < 10 && !outst; i++) cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 32'h30000200);
    repeat (6) cyc(1, 0, 0, 1, 0);
    // PC wrap at the top of the address space
    for (int i = 0; i < 10 && !(icache_req_o && !outst); i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 32'hFFFFFFF8);
    repeat (10) cyc(1, 0, 0, 1, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 2) != 0, $urandom);
    // asynchronous reset in the middle of a held group
    cyc(1, 0, 0, 1, 0);
    for (int i = 0; i < 30 && !pend; i++) cyc(1, 1, 0, 1, 0);
    chk("hold_reached", pend, 1);
    cyc(1, 1, 0, 1, 0);
    #2 rst = 1;
    #1;
    chk("arst_en1", fetch_inst_1_en, 0);
    chk("arst_inst1", inst_1_o, 0);
    chk("arst_pc1", pc_1_o, 0);
    chk("arst_addr", icache_addr_o, RST_PC);
    flush = 0; stall_i = 0; rdy = 0; rvalid = 0;
    exp_pc = RST_PC; outst = 0; stale = 0; pend = 0; exp_en = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (8) cyc(1, 0, 0, 1, 0);
    chk("progress", groups > 100, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
